// File: rtl/fir_mac_param.sv
// fir_mac_param: parametrised, time-multiplexed FIR engine.
// Computes y = sum_i c[i]*s[i] over TAPS taps, using LANES multipliers per cycle
// (G = TAPS/LANES groups). The result is right-shifted by out_shift and saturated
// to DW bits in the selected signed/unsigned mode.
//
// Ports:
//   clk         clock, all flops on posedge
//   rstb        asynchronous active-low reset
//   coef_wr     shift coef_data into the coefficient register (IDLE only)
//   coef_data   coefficient word
//   samp_valid  sample offered
//   samp_ready  sample accepted when samp_valid && samp_ready (IDLE only)
//   samp_data   sample word
//   start       begin one convolution over the current contents (IDLE only)
//   signed_mode 1 = two's-complement operands and saturation, 0 = unsigned
//   out_shift   right shift applied to the accumulator before saturation
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   out_data    saturated result
//   busy        high in any state other than IDLE
module fir_mac_param #(
  parameter int unsigned DW    = 16,
  parameter int unsigned TAPS  = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACCW  = 2 * DW + $clog2(TAPS),
  parameter int unsigned SHW   = $clog2(2 * DW)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           coef_wr,
  input  logic [DW-1:0]  coef_data,
  input  logic           samp_valid,
  output logic           samp_ready,
  input  logic [DW-1:0]  samp_data,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [SHW-1:0] out_shift,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           busy
);

  localparam int unsigned G  = TAPS / LANES;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW = 2 * DW;

  if ((TAPS % LANES) != 0) begin : g_bad_taps
    $error("TAPS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StMac, StDrain, StHold} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [1:0]      drain_q, drain_d;

  logic [DW-1:0]   coef_q [TAPS];
  logic [DW-1:0]   samp_q [TAPS];

  // Operating mode captured at start so the caller may change the inputs mid-run.
  logic            mode_q;
  logic [SHW-1:0]  shift_q;

  logic [DW-1:0]   coef_sel [LANES];
  logic [DW-1:0]   samp_sel [LANES];
  logic [PW-1:0]   prod_d   [LANES];
  logic [PW-1:0]   prod_q   [LANES];
  logic            prod_vld_q;

  logic [ACCW-1:0] sum_d, sum_q;
  logic            sum_vld_q;
  logic [ACCW-1:0] acc_q;

  logic signed [ACCW-1:0] acc_s, sh_s, smax, smin;
  logic [ACCW-1:0] sh_u;
  logic [DW-1:0]   sat;
  logic [DW-1:0]   out_data_q;

  logic in_idle, samp_fire, coef_fire, start_fire, load_out;

  assign in_idle    = (state_q == StIdle);
  assign samp_fire  = samp_valid && in_idle;
  assign coef_fire  = coef_wr && in_idle;
  assign start_fire = start && in_idle;
  // Last drain cycle: accumulator holds the final sum, so capture the result now.
  assign load_out   = (state_q == StDrain) && (drain_q == 2'd2);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          grp_d   = '0;
        end
      end
      StMac: begin
        if (grp_q == GW'(G - 1)) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 2'd2) begin
          state_d = StHold;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      grp_q   <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      drain_q <= drain_d;
      if (start_fire) begin
        mode_q  <= signed_mode;
        shift_q <= out_shift;
      end
    end
  end

  // Coefficient and sample shift registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        coef_q[i] <= '0;
        samp_q[i] <= '0;
      end
    end else begin
      if (coef_fire) begin
        coef_q[0] <= coef_data;
        for (int i = 1; i < int'(TAPS); i++) begin
          coef_q[i] <= coef_q[i-1];
        end
      end
      if (samp_fire) begin
        samp_q[0] <= samp_data;
        for (int i = 1; i < int'(TAPS); i++) begin
          samp_q[i] <= samp_q[i-1];
        end
      end
    end
  end

  // Stage 1: select the current tap group and form LANES products
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      coef_sel[l] = coef_q[TW'(int'(grp_q) * int'(LANES) + l)];
      samp_sel[l] = samp_q[TW'(int'(grp_q) * int'(LANES) + l)];
      if (mode_q) begin
        prod_d[l] = {{DW{coef_sel[l][DW-1]}}, coef_sel[l]}
                  * {{DW{samp_sel[l][DW-1]}}, samp_sel[l]};
      end else begin
        prod_d[l] = {{DW{1'b0}}, coef_sel[l]} * {{DW{1'b0}}, samp_sel[l]};
      end
    end
  end

  // Stage 2: adder tree, products extended to accumulator width per mode
  always_comb begin
    sum_d = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (mode_q) begin
        sum_d = sum_d + ACCW'($signed(prod_q[l]));
      end else begin
        sum_d = sum_d + ACCW'(prod_q[l]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int l = 0; l < int'(LANES); l++) begin
        prod_q[l] <= '0;
      end
      prod_vld_q <= 1'b0;
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      acc_q      <= '0;
    end else begin
      for (int l = 0; l < int'(LANES); l++) begin
        prod_q[l] <= prod_d[l];
      end
      prod_vld_q <= (state_q == StMac);
      sum_q      <= sum_d;
      sum_vld_q  <= prod_vld_q;
      // Stage 3: accumulate; clears on the IDLE->MAC transition
      if (start_fire) begin
        acc_q <= '0;
      end else if (sum_vld_q) begin
        acc_q <= acc_q + sum_q;
      end
    end
  end

  // Output shift and saturation. Kept in separate signed/unsigned variables so the
  // arithmetic shift is not silently turned into a logical one by mixed signedness.
  always_comb begin
    acc_s = acc_q;
    sh_s  = acc_s >>> shift_q;
    sh_u  = acc_q >> shift_q;
    smax  = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    smin  = {{(ACCW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
    sat   = '0;
    if (mode_q) begin
      if (sh_s > smax) begin
        sat = {1'b0, {(DW - 1){1'b1}}};
      end else if (sh_s < smin) begin
        sat = {1'b1, {(DW - 1){1'b0}}};
      end else begin
        sat = sh_s[DW-1:0];
      end
    end else begin
      if (|sh_u[ACCW-1:DW]) begin
        sat = '1;
      end else begin
        sat = sh_u[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_data_q <= '0;
    end else if (load_out) begin
      out_data_q <= sat;
    end
  end

  assign samp_ready = in_idle;
  assign busy       = !in_idle;
  assign out_valid  = (state_q == StHold);
  assign out_data   = out_data_q;

endmodule

// File: doc/fir_mac_param.md
Name: fir_mac_param

Overview:
Parametrised, time-multiplexed FIR engine. It is the successor to the fixed 16-tap, 4-lane FIR and computes y = sum over i of c[i]*s[i] across TAPS taps, using LANES multipliers per cycle. New in this generation: configurable width, depth and lane count, a signed/unsigned mode, a programmable output shift with saturation, and valid/ready handshakes on both the sample and output sides. It sits between the sample front-end and the downstream post-processing stream.

Parameters:
DW, 16, sample/coefficient/output width in bits
TAPS, 16, number of taps; must be a multiple of LANES
LANES, 4, parallel multipliers; TAPS/LANES = G groups
ACCW, 2*DW+$clog2(TAPS), accumulator width
SHW, $clog2(2*DW), width of out_shift

Ports:
clk  in  1  clock; all flops on posedge
rstb  in  1  reset rstb, asynchronous, active-low
coef_wr  in  1  shift coef_data into coefficient register
coef_data  in  DW  coefficient word
samp_valid  in  1  sample offered
samp_ready  out  1  sample accepted when samp_valid && samp_ready
samp_data  in  DW  sample word
start  in  1  begin one convolution over the current contents
signed_mode  in  1  1 = two's-complement operands and saturation; 0 = unsigned
out_shift  in  SHW  arithmetic right shift applied to the accumulator before saturation
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  DW  saturated result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all coefficient and sample registers 0, state IDLE, accumulator 0. Outputs: out_valid 0, out_data 0, busy 0, samp_ready 1.
- Coefficient shift: on coef_wr in IDLE, c[i] <= c[i-1] and c[0] <= coef_data. After TAPS writes, the first word written sits in c[TAPS-1]. coef_wr is ignored outside IDLE.
- Sample shift: on samp_valid && samp_ready, s[i] <= s[i-1] and s[0] <= samp_data. samp_ready = (state == IDLE).
- FSM: IDLE -> MAC when start is high in IDLE. If coef_wr or a sample handshake occurs in the same cycle as start, the shift happens first and the MAC uses the updated contents.
  - MAC: runs G cycles. The group counter g = 0..G-1 selects taps g*LANES to g*LANES+LANES-1. The state then goes to DRAIN.
  - DRAIN: 3 cycles to flush the pipeline, then HOLD.
  - HOLD: out_valid = 1; on out_ready the state returns to IDLE.
- start is ignored outside IDLE.
- Pipeline:
  - Stage 1 registers LANES products, each 2*DW bits wide, sign- or zero-extended per signed_mode.
  - Stage 2 registers the adder-tree sum.
  - Stage 3 accumulates into ACCW bits. The accumulator clears on the IDLE->MAC transition.
- Latency: out_valid rises exactly G+3 cycles after the clock edge that sampled start. Default is 7.
- Output: r = acc >>> out_shift (logical shift when unsigned).
  - Signed mode: clamp r to [-2^(DW-1), 2^(DW-1)-1].
  - Unsigned mode: clamp r to [0, 2^DW-1].
  - out_data is registered on entry to HOLD and held stable until the handshake completes.
- signed_mode and out_shift are sampled at start and held internally for the whole operation.
- Backpressure: while out_ready is low, out_valid, out_data and busy all stay asserted and no new sample is accepted.
- Reset mid-operation: rstb low aborts immediately. All state returns to the reset values, including coefficients and samples.
- The accumulator never wraps, because ACCW covers the worst-case sum.

Test Plan:
- Reset values: assert rstb low mid-MAC -> next cycle out_valid=0, busy=0, samp_ready=1, out_data=0, coefficients cleared.
- Unsigned sum: 16 coef_wr of 1, samples 1..16, signed_mode=0, out_shift=0, start, out_ready=1 -> out_valid exactly 7 cycles after start, out_data=136, one-cycle pulse, back to IDLE.
- Signed mode: coefficients all 0xFFFF, samples 1..16, signed_mode=1 -> out_data=0xFF78 (-136). Same stimulus with signed_mode=0 -> saturates to 0xFFFF.
- Shift and saturation:
  - Coefficients 1, samples 1..16, out_shift=3 -> 17.
  - Coefficients and samples all 0x7FFF, signed, shift 0 -> 0x7FFF.
  - Coefficients 0x8000, samples 0x7FFF, signed -> 0x8000.
- Backpressure: out_ready held low 5 cycles after out_valid -> out_valid and out_data stable, samp_ready=0, sample offers not accepted. start pulsed during HOLD is ignored. Release -> one transfer, then IDLE.
- Concurrency: start in the same cycle as a sample handshake -> the result includes the new s[0]. coef_wr during MAC -> coefficients unchanged and the result matches the pre-start coefficients. Run a parameter sweep: TAPS=8/LANES=2 and TAPS=32/LANES=8, with latency G+3 = 7 and 7.
